// File: rtl/vcfg_sequencer_pkg.sv
// Vector configuration types, FSM states and vtype/VLMAX helpers for vcfg_sequencer.
// Fractional LMUL legality is selected by the ARA_VCFG_FRACTIONAL_LMUL_EN macro.
package vcfg_sequencer_pkg;

  localparam logic [6:0] OPCODE_V     = 7'b1010111;
  localparam logic [2:0] FUNCT3_OPCFG = 3'b111;

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} vcfg_state_e;

  typedef enum logic [2:0] {
    LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSVD, LMUL_1_8, LMUL_1_4, LMUL_1_2
  } vlmul_e;

  // Raw vtype field as it arrives in zimm / rs2[7:0].
  typedef struct packed {
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_raw_t;

  // Stored vtype: only SEW 8..64 can ever be legal, so vsew needs two bits.
  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [1:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  localparam vtype_t VTYPE_ILL = vtype_t'(8'h80);

  function automatic int unsigned vlmax(vtype_raw_t vt, int unsigned vlen);
    int unsigned base;
    logic [2:0]  frac_shift;
    base       = (vlen >> 3) >> vt.vsew;
    frac_shift = 3'd4 - {1'b0, vt.vlmul[1:0]};
    if (vt.vlmul[2]) return base >> frac_shift;
    return base << vt.vlmul[1:0];
  endfunction

  function automatic logic vtype_legal(vtype_raw_t vt, int unsigned elen);
    int unsigned sew;
    logic [2:0]  frac_shift;
    sew        = 8 << vt.vsew;
    frac_shift = 3'd4 - {1'b0, vt.vlmul[1:0]};
    if (vt.vlmul == LMUL_RSVD) return 1'b0;
    if (sew > elen) return 1'b0;
    if (vt.vlmul[2]) begin
`ifdef ARA_VCFG_FRACTIONAL_LMUL_EN
      if (sew > (elen >> frac_shift)) return 1'b0;
`else
      if (frac_shift != 3'd0) return 1'b0;
`endif
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/vcfg_sequencer_vlmax.sv
// Combinational vtype legalisation, VLMAX computation and new-vl selection.
module vcfg_sequencer_vlmax
  import vcfg_sequencer_pkg::*;
#(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64,
  parameter int unsigned XLEN = 64,
  parameter int unsigned VlW  = $clog2(VLEN) + 1
) (
  input  logic [7:0]      vtype_raw,
  input  logic            vtype_hi_set,
  input  logic [XLEN-1:0] avl,
  input  logic            keep_vl,
  input  logic [VlW-1:0]  cur_vl,
  output logic [7:0]      new_vtype,
  output logic [VlW-1:0]  new_vl
);

  vtype_raw_t     raw;
  logic           legal;
  logic [VlW-1:0] vlmax_v;

  always_comb begin
    raw       = vtype_raw_t'(vtype_raw);
    legal     = !vtype_hi_set && vtype_legal(raw, ELEN);
    vlmax_v   = VlW'(vlmax(raw, VLEN));
    new_vtype = VTYPE_ILL;
    new_vl    = '0;
    if (legal) begin
      new_vtype = {1'b0, raw.vma, raw.vta, raw.vsew[1:0], raw.vlmul};
      if (keep_vl) begin
        new_vl = (cur_vl < vlmax_v) ? cur_vl : vlmax_v;
      end else begin
        // Full-width compare so a huge AVL never aliases to a small vl.
        new_vl = (avl < XLEN'(vlmax_v)) ? avl[VlW-1:0] : vlmax_v;
      end
    end
  end

endmodule

// File: rtl/vcfg_sequencer.sv
// Vector configuration sequencer: executes vsetvli/vsetivli/vsetvl and owns vl/vtype/vstart.
// Fractional LMUL support is enabled by defining ARA_VCFG_FRACTIONAL_LMUL_EN.
module vcfg_sequencer
  import vcfg_sequencer_pkg::*;
#(
  parameter  int unsigned VLEN = 4096,
  parameter  int unsigned ELEN = 64,
  parameter  int unsigned XLEN = 64,
  localparam int unsigned VlW  = $clog2(VLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_instr_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output logic            resp_illegal_o,
  input  logic            backend_idle_i,
  output logic [VlW-1:0]  vl_o,
  output logic [7:0]      vtype_o,
  output logic [VlW-1:0]  vstart_o,
  output logic            cfg_update_o
);

  logic [4:0]      rd, rs1;
  logic            is_vsetvli, is_vsetivli, is_vsetvl, legal_instr;
  logic            vtype_hi_set, keep_vl;
  logic [7:0]      vtype_raw;
  logic [XLEN-1:0] avl;
  vtype_t          calc_vtype;
  logic [VlW-1:0]  calc_vl;

  vcfg_state_e     state_reg;
  vtype_t          vtype_reg, pend_vtype_reg;
  logic [VlW-1:0]  vl_reg, vstart_reg, pend_vl_reg;
  logic [XLEN-1:0] result_reg;
  logic            illegal_reg, cfg_update_reg;

  always_comb begin
    rd          = req_instr_i[11:7];
    rs1         = req_instr_i[19:15];
    is_vsetvli  = !req_instr_i[31];
    is_vsetivli = req_instr_i[31:30] == 2'b11;
    is_vsetvl   = req_instr_i[31:25] == 7'b1000000;
    legal_instr = (req_instr_i[6:0] == OPCODE_V) && (req_instr_i[14:12] == FUNCT3_OPCFG)
                  && (is_vsetvli || is_vsetivli || is_vsetvl);
    vtype_raw   = is_vsetvl ? req_rs2_i[7:0] : req_instr_i[27:20];
    if (is_vsetvl)        vtype_hi_set = |req_rs2_i[XLEN-1:8];
    else if (is_vsetivli) vtype_hi_set = |req_instr_i[29:28];
    else                  vtype_hi_set = |req_instr_i[30:28];
    // rs1=x0 with rd=x0 keeps the current vl (clipped) instead of using an AVL.
    keep_vl = 1'b0;
    if (is_vsetivli)        avl = XLEN'(rs1);
    else if (rs1 != 5'd0)   avl = req_rs1_i;
    else if (rd != 5'd0)    avl = '1;
    else begin
      avl     = '0;
      keep_vl = 1'b1;
    end
  end

  vcfg_sequencer_vlmax #(
    .VLEN(VLEN), .ELEN(ELEN), .XLEN(XLEN), .VlW(VlW)
  ) u_vlmax (
    .vtype_raw   (vtype_raw),
    .vtype_hi_set(vtype_hi_set),
    .avl         (avl),
    .keep_vl     (keep_vl),
    .cur_vl      (vl_reg),
    .new_vtype   (calc_vtype),
    .new_vl      (calc_vl)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      vtype_reg      <= VTYPE_ILL;
      vl_reg         <= '0;
      vstart_reg     <= '0;
      pend_vtype_reg <= VTYPE_ILL;
      pend_vl_reg    <= '0;
      result_reg     <= '0;
      illegal_reg    <= 1'b0;
      cfg_update_reg <= 1'b0;
    end else begin
      cfg_update_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            illegal_reg <= !legal_instr;
            if (!legal_instr) begin
              result_reg <= '0;
              state_reg  <= RESP;
            end else begin
              result_reg     <= XLEN'(calc_vl);
              pend_vtype_reg <= calc_vtype;
              pend_vl_reg    <= calc_vl;
              // Only a vtype change must wait for in-flight vector work to drain.
              if (calc_vtype == vtype_reg || backend_idle_i) begin
                vtype_reg      <= calc_vtype;
                vl_reg         <= calc_vl;
                vstart_reg     <= '0;
                cfg_update_reg <= 1'b1;
                state_reg      <= RESP;
              end else begin
                state_reg <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (backend_idle_i) begin
            vtype_reg      <= pend_vtype_reg;
            vl_reg         <= pend_vl_reg;
            vstart_reg     <= '0;
            cfg_update_reg <= 1'b1;
            state_reg      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (state_reg == IDLE);
  assign resp_valid_o   = (state_reg == RESP);
  assign resp_result_o  = result_reg;
  assign resp_illegal_o = illegal_reg;
  assign vl_o           = vl_reg;
  assign vtype_o        = vtype_reg;
  assign vstart_o       = vstart_reg;
  assign cfg_update_o   = cfg_update_reg;

endmodule
